// File: rtl/vga_pixel_fetch.sv
// SRAM master for the VGA scan: pipelined pixel reads while visible, write-FIFO drain in blanking.
// Build option VGA_TEST_PATTERN_EN adds a test_mode input that swaps in 8 vertical colour bars.
module vga_pixel_fetch #(
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned WF_DEPTH = 8
) (
    input  logic              clk_25mhz,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] ctl_addr,
    input  logic              ctl_video_on,
    input  logic              ctl_hsync,
    input  logic              ctl_vsync,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync
);

    localparam int unsigned L     = RD_LAT + 2;
    localparam int unsigned PTR_W = $clog2(WF_DEPTH);

    typedef enum logic [1:0] {StRead, StTurn, StWrite, StIdle} state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_fifo_addr [WF_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [WF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;

    // RGB register is the last delay stage, so video_on needs one fewer stage than the syncs.
    logic [L-2:0]      r_vo;
    logic [L-1:0]      r_hs;
    logic [L-1:0]      r_vs;

    assign wr_ready  = (r_count != (PTR_W+1)'(WF_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = wr_valid && wr_ready;
    // Leaving READ always costs one turnaround cycle before the first pop.
    assign w_pop     = en && !ctl_video_on && !w_empty && (r_state != StRead);
    assign vga_hsync = r_hs[L-1];
    assign vga_vsync = r_vs[L-1];

    always_ff @(posedge clk_25mhz) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else if (!en) begin
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
        end else if (ctl_video_on) begin
            r_state   <= StRead;
            sram_addr <= ctl_addr;
            sram_oe_n <= 1'b0;
            sram_we_n <= 1'b1;
        end else if (w_pop) begin
            r_state    <= StWrite;
            sram_addr  <= r_fifo_addr[r_rd_ptr];
            sram_wdata <= r_fifo_data[r_rd_ptr];
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b0;
        end else begin
            r_state   <= (r_state == StRead) ? StTurn : StIdle;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [ADDR_W-1:0] w_col;
    logic [2:0]        w_bar;
    logic [DATA_W-1:0] w_pat;
    logic [DATA_W-1:0] r_pat [L-1];
    logic [L-2:0]      r_tm;

    assign w_col = ctl_addr % ADDR_W'(640);
    assign w_bar = 3'(w_col / ADDR_W'(80));

    always_comb begin
        w_pat = '0;
        case (w_bar)
            3'd0:    w_pat = 12'hFFF;
            3'd1:    w_pat = 12'hFF0;
            3'd2:    w_pat = 12'h0FF;
            3'd3:    w_pat = 12'h0F0;
            3'd4:    w_pat = 12'hF0F;
            3'd5:    w_pat = 12'hF00;
            3'd6:    w_pat = 12'h00F;
            default: w_pat = 12'h000;
        endcase
    end
`endif

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_vo <= '0;
            r_hs <= '1;
            r_vs <= '1;
            {vga_r, vga_g, vga_b} <= '0;
`ifdef VGA_TEST_PATTERN_EN
            r_tm <= '0;
            for (int i = 0; i < int'(L) - 1; i++) r_pat[i] <= '0;
`endif
        end else if (en) begin
            r_vo <= {r_vo[L-3:0], ctl_video_on};
            r_hs <= {r_hs[L-2:0], ctl_hsync};
            r_vs <= {r_vs[L-2:0], ctl_vsync};
`ifdef VGA_TEST_PATTERN_EN
            r_tm     <= {r_tm[L-3:0], test_mode};
            r_pat[0] <= w_pat;
            for (int i = 1; i < int'(L) - 1; i++) r_pat[i] <= r_pat[i-1];
`endif
            if (!r_vo[L-2]) begin
                {vga_r, vga_g, vga_b} <= '0;
            end
`ifdef VGA_TEST_PATTERN_EN
            else if (r_tm[L-2]) begin
                {vga_r, vga_g, vga_b} <= r_pat[L-2];
            end
`endif
            else begin
                {vga_r, vga_g, vga_b} <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: reset, visible stream, blanking writes, FIFO full, en stall.
`timescale 1ns/1ps
module tb_vga_pixel_fetch;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned RD_LAT = 2;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic              clk_25mhz = 1'b0;
    logic              rst_n;
    logic              en;
    logic [ADDR_W-1:0] ctl_addr;
    logic              ctl_video_on;
    logic              ctl_hsync;
    logic              ctl_vsync;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic [3:0]        vga_r;
    logic [3:0]        vga_g;
    logic [3:0]        vga_b;
    logic              vga_hsync;
    logic              vga_vsync;
`ifdef VGA_TEST_PATTERN_EN
    logic              test_mode = 1'b0;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        hist[$];
    logic [ADDR_W-1:0] s_pipe [RD_LAT];

    vga_pixel_fetch dut (
        .clk_25mhz   (clk_25mhz),
        .rst_n       (rst_n),
        .en          (en),
        .ctl_addr    (ctl_addr),
        .ctl_video_on(ctl_video_on),
        .ctl_hsync   (ctl_hsync),
        .ctl_vsync   (ctl_vsync),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .sram_addr   (sram_addr),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    // SRAM returns the low 12 address bits, RD_LAT enabled cycles after the address.
    initial for (int i = 0; i < int'(RD_LAT); i++) s_pipe[i] = '0;
    always @(posedge clk_25mhz) begin
        if (en) begin
            s_pipe[0] <= sram_addr;
            for (int i = 1; i < int'(RD_LAT); i++) s_pipe[i] <= s_pipe[i-1];
        end
    end
    assign sram_rdata = s_pipe[RD_LAT-1][DATA_W-1:0];

`ifdef VGA_TEST_PATTERN_EN
    function automatic logic [11:0] bar_rgb(input logic [ADDR_W-1:0] a);
        logic [11:0] tbl [8];
        tbl = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        return tbl[(a % 640) / 80];
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: inputs already set; after the edge compare outputs against the sample 3 edges back.
    task automatic step();
        exp_t e;
        logic was_en;
        was_en = en && rst_n;
        e.rgb  = ctl_video_on ? ctl_addr[11:0] : 12'h000;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode && ctl_video_on) e.rgb = bar_rgb(ctl_addr);
`endif
        e.hs = ctl_hsync;
        e.vs = ctl_vsync;
        @(negedge clk_25mhz);
        if (was_en) hist.push_back(e);
        if (rst_n) begin
            e = hist[hist.size() - 4];
            check("rgb", {vga_r, vga_g, vga_b}, e.rgb);
            check("hsync", vga_hsync, e.hs);
            check("vsync", vga_vsync, e.vs);
        end
    endtask

    task automatic reset_hist();
        hist.delete();
        repeat (3) hist.push_back('{rgb: 12'h000, hs: 1'b1, vs: 1'b1});
    endtask

    logic [ADDR_W-1:0] exp_wa [3];
    logic [DATA_W-1:0] exp_wd [3];

    initial begin
        rst_n = 1'b0; en = 1'b1; ctl_addr = '0; ctl_video_on = 1'b0;
        ctl_hsync = 1'b1; ctl_vsync = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk_25mhz);
        rst_n = 1'b1;
        reset_hist();

        // Reset with five FIFO entries pending.
        ctl_video_on = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ctl_addr = ADDR_W'(k); wr_valid = 1'b1;
            wr_addr = ADDR_W'(50 + k); wr_data = 12'hA00 + 12'(k);
            step();
        end
        wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_sram_addr", sram_addr, 0);
        check("rst_wdata", sram_wdata, 0);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_hsync", vga_hsync, 1);
        check("rst_vsync", vga_vsync, 1);
        check("rst_wr_ready", wr_ready, 1);
        repeat (3) @(negedge clk_25mhz);
        rst_n = 1'b1;
        reset_hist();
        ctl_video_on = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check("post_rst_we_n", sram_we_n, 1);
        end

        // Visible line 0..639 then blanking with sync pulses.
        ctl_video_on = 1'b1;
        for (int i = 0; i < 640; i++) begin
            ctl_addr = ADDR_W'(i);
            step();
            if (i == 10) check("rgb_spot10", {vga_r, vga_g, vga_b}, 12'h007);
        end
        ctl_video_on = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ctl_hsync = !(k >= 4 && k < 10);
            ctl_vsync = !(k >= 6 && k < 8);
            step();
            if (k == 2) check("rgb_last_px", {vga_r, vga_g, vga_b}, 12'h27F);
            if (k == 3) check("rgb_blank", {vga_r, vga_g, vga_b}, 12'h000);
            if (k == 6) check("hs_before", vga_hsync, 1);
            if (k == 7) check("hs_low", vga_hsync, 0);
        end

        // Host writes during visible; drained after one turnaround cycle.
        exp_wa = '{19'd100, 19'd101, 19'd102};
        exp_wd = '{12'hF00, 12'h0F0, 12'h00F};
        ctl_video_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ctl_addr = ADDR_W'(i);
            wr_valid = (i >= 2 && i < 5);
            if (wr_valid) begin
                wr_addr = exp_wa[i-2]; wr_data = exp_wd[i-2];
            end
            step();
            check("vis_we_n", sram_we_n, 1);
            check("vis_oe_n", sram_oe_n, 0);
        end
        wr_valid = 1'b0;
        ctl_video_on = 1'b0;
        step();
        check("turn_oe_n", sram_oe_n, 1);
        check("turn_we_n", sram_we_n, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("wr_we_n", sram_we_n, 0);
            check("wr_oe_n", sram_oe_n, 1);
            check("wr_addr", sram_addr, exp_wa[k]);
            check("wr_data", sram_wdata, exp_wd[k]);
        end
        step();
        check("wr_done_we_n", sram_we_n, 1);

        // Nine pushes with no blanking: the ninth waits for one pop.
        ctl_video_on = 1'b1;
        wr_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("fill_ready", wr_ready, 1);
            ctl_addr = ADDR_W'(k); wr_addr = ADDR_W'(200 + k); wr_data = 12'h300 + 12'(k);
            step();
        end
        check("full_ready", wr_ready, 0);
        wr_addr = ADDR_W'(208); wr_data = 12'h308;
        repeat (2) begin
            step();
            check("held_ready", wr_ready, 0);
        end
        ctl_video_on = 1'b0;
        step();
        check("full_turn_ready", wr_ready, 0);
        step();
        check("pop_we_n", sram_we_n, 0);
        check("pop_addr", sram_addr, 200);
        check("pop_ready", wr_ready, 1);
        ctl_video_on = 1'b1;
        step();
        check("refill_ready", wr_ready, 0);
        wr_valid = 1'b0;
        ctl_video_on = 1'b0;
        step();
        for (int k = 1; k < 9; k++) begin
            step();
            check("drain_we_n", sram_we_n, 0);
            check("drain_addr", sram_addr, 200 + k);
            check("drain_data", sram_wdata, 12'h300 + k);
        end
        step();
        check("drained_we_n", sram_we_n, 1);
        check("drained_ready", wr_ready, 1);

        // en low for 10 cycles mid-line; ctl_addr garbage while stalled.
        ctl_video_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ctl_addr = ADDR_W'(i);
            step();
            if (i == 20) begin
                en = 1'b0;
                ctl_addr = 19'h7FFFF;
                repeat (10) begin
                    step();
                    check("stall_addr", sram_addr, 20);
                    check("stall_oe_n", sram_oe_n, 1);
                    check("stall_we_n", sram_we_n, 1);
                    check("stall_rgb", {vga_r, vga_g, vga_b}, 12'h011);
                end
                en = 1'b1;
            end
        end
        ctl_video_on = 1'b0;
        repeat (6) step();

`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b1;
        ctl_video_on = 1'b1;
        for (int i = 0; i < 640; i++) begin
            ctl_addr = ADDR_W'(i);
            step();
            if (i == 82)  check("bar0_end", {vga_r, vga_g, vga_b}, 12'hFFF);
            if (i == 83)  check("bar1_start", {vga_r, vga_g, vga_b}, 12'hFF0);
            if (i == 562) check("bar6_end", {vga_r, vga_g, vga_b}, 12'h00F);
            if (i == 563) check("bar7_start", {vga_r, vga_g, vga_b}, 12'h000);
        end
        ctl_video_on = 1'b0;
        repeat (6) step();
        test_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
